// File: rtl/kpn_pkg.sv
// Shared constants, state encoding and digit helper for the KPN sink.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH = 16;
  localparam int KPN_BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2,
    HOLD    = 2'd3
  } kpn_state_e;

  // Double-dabble correction: a digit that would reach >=10 after the shift is pre-adjusted.
  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/kpn_sink_module_bcd_add3_digit.sv
// Combinational per-digit conditional +3 for the shift-add-3 converter.
// Zero latency; no flow control.
module bcd_add3_digit
  import kpn_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = bcd_add3(digit_in);

endmodule

// File: rtl/kpn_sink_module.sv
// KPN terminal consumer: pops one token when not empty, converts it to packed BCD in DATA_WIDTH cycles.
// rd-to-done latency DATA_WIDTH+1; no pop while busy, so the FIFO simply holds tokens until IDLE.
module kpn_sink_module
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH  = KPN_DATA_WIDTH,
  parameter int BCD_DIGITS  = KPN_BCD_DIGITS,
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    empty,
  input  logic [DATA_WIDTH-1:0]   entry_1,
  output logic                    rd,
  output logic [4*BCD_DIGITS-1:0] bcd_number,
  output logic                    done,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    token_count
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  kpn_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]         scr_q, scr_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]         scr_adj;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_in  (scr_q[4*i +: 4]),
      .digit_out (scr_adj[4*i +: 4])
    );
  end

  assign rd          = (state_q == IDLE) && !empty;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign bcd_number  = bcd_q;
  assign token_count = cnt_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    iter_d  = iter_q;
    hold_d  = hold_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          bin_d   = entry_1;
          scr_d   = '0;
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Digits shifted out of the top are dropped, which truncates oversize values.
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        iter_d = iter_q + IW'(1);
        if (iter_q == ITER_LAST) begin
          iter_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scr_q;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        hold_d  = '0;
        state_d = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      iter_q  <= '0;
      hold_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      iter_q  <= iter_d;
      hold_q  <= hold_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_kpn_sink_module.sv
// Three sink instances (default, HOLD_CYCLES=3, CNT_WIDTH=2) fed from bench FIFOs and checked
// every cycle against a timeline model: pop when idle, done 17 cycles later, result then held.
module tb_kpn_sink_module;

  localparam int NI = 3;
  localparam int HOLD_OF [NI] = '{0, 3, 0};
  localparam logic [7:0] CMASK [NI] = '{8'hFF, 8'hFF, 8'h03};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty_i [NI];
  logic [15:0] entry_i [NI];
  logic        rd_o    [NI];
  logic        done_o  [NI];
  logic        busy_o  [NI];
  logic [19:0] bcd_o   [NI];
  logic [7:0]  cnt_o   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    if (g == 2) begin : g_small
      logic [1:0] c;
      kpn_sink_module #(.HOLD_CYCLES(0), .CNT_WIDTH(2)) u_dut (
        .clk(clk), .reset(rst), .empty(empty_i[g]), .entry_1(entry_i[g]), .rd(rd_o[g]),
        .bcd_number(bcd_o[g]), .done(done_o[g]), .busy(busy_o[g]), .token_count(c));
      assign cnt_o[g] = {6'd0, c};
    end else begin : g_full
      kpn_sink_module #(.HOLD_CYCLES(HOLD_OF[g]), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .reset(rst), .empty(empty_i[g]), .entry_1(entry_i[g]), .rd(rd_o[g]),
        .bcd_number(bcd_o[g]), .done(done_o[g]), .busy(busy_o[g]), .token_count(cnt_o[g]));
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Bench FIFOs
  logic [15:0] fmem [NI][1024];
  int wp [NI] = '{default: 0};
  int rp [NI] = '{default: 0};
  bit pop_pend [NI] = '{default: 0};
  bit rnd_mode = 0;

  task automatic push(input int g, input logic [15:0] v);
    fmem[g][wp[g]] = v;
    wp[g]++;
  endtask

  initial begin : drv
    bit gap;
    for (int g = 0; g < NI; g++) begin
      empty_i[g] = 1'b1;
      entry_i[g] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        if (pop_pend[g]) begin
          rp[g]++;
          pop_pend[g] = 0;
        end
        gap = rnd_mode && ($urandom_range(0, 3) == 0);
        empty_i[g] = rst || gap || (rp[g] == wp[g]);
        entry_i[g] = (rp[g] != wp[g]) ? fmem[g][rp[g]] : 16'($urandom);
      end
    end
  end

  // Model state: tmr = cycles since the pop (0 = idle)
  int          cyc = 0;
  int          tmr      [NI] = '{default: 0};
  logic [15:0] tok      [NI];
  logic [19:0] exp_bcd  [NI] = '{default: 0};
  logic [7:0]  exp_cnt  [NI] = '{default: 0};
  int          rd_seen  [NI] = '{default: 0};
  int          dn_seen  [NI] = '{default: 0};
  int          rcyc     [NI][256];
  int          dcyc     [NI][256];
  bit          obs_pend [NI] = '{default: 0};
  logic [19:0] obs_bcd  [NI][256];
  logic [7:0]  obs_cnt  [NI][256];

  always @(negedge clk) begin : model
    bit e_rd;
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        tmr[g] = 0;
        exp_bcd[g] = '0;
        exp_cnt[g] = '0;
        obs_pend[g] = 0;
      end
      e_rd = (tmr[g] == 0) && !empty_i[g] && !rst;
      chk($sformatf("rd[%0d]", g), rd_o[g], e_rd);
      chk($sformatf("done[%0d]", g), done_o[g], tmr[g] == 17);
      chk($sformatf("busy[%0d]", g), busy_o[g], tmr[g] > 0);
      chk($sformatf("bcd[%0d]", g), bcd_o[g], exp_bcd[g]);
      chk($sformatf("cnt[%0d]", g), cnt_o[g], exp_cnt[g]);
      if (obs_pend[g]) begin
        obs_bcd[g][(dn_seen[g] - 1) % 256] = bcd_o[g];
        obs_cnt[g][(dn_seen[g] - 1) % 256] = cnt_o[g];
        obs_pend[g] = 0;
      end
      if (rd_o[g]) begin
        rcyc[g][rd_seen[g] % 256] = cyc;
        rd_seen[g]++;
      end
      if (done_o[g]) begin
        dcyc[g][dn_seen[g] % 256] = cyc;
        dn_seen[g]++;
        obs_pend[g] = 1;
      end
      if (!rst) begin
        if (tmr[g] == 17) begin
          exp_bcd[g] = to_bcd(int'(tok[g]));
          exp_cnt[g] = (exp_cnt[g] + 8'd1) & CMASK[g];
        end
        if (tmr[g] > 0) begin
          tmr[g] = (tmr[g] == 17 + HOLD_OF[g]) ? 0 : tmr[g] + 1;
        end else if (e_rd) begin
          tmr[g] = 1;
          tok[g] = entry_i[g];
          pop_pend[g] = 1;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int g, input int n, input int budget);
    int t;
    t = 0;
    while (dn_seen[g] < n && t < budget) begin
      wait_cyc(1);
      t++;
    end
    chk($sformatf("done_timeout[%0d]", g), dn_seen[g] >= n, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int  t;
    bit  act;
    t = 0;
    act = 1;
    while (act && t < budget) begin
      wait_cyc(1);
      t++;
      act = 0;
      for (int g = 0; g < NI; g++) act |= (rp[g] != wp[g]) || busy_o[g];
    end
    chk("idle_timeout", act, 1'b0);
  endtask

  initial begin : main
    logic [19:0] seq_bcd [4];
    logic [7:0]  seq_cnt [5];
    int          b_rd, b_dn;
    seq_bcd = '{20'h00000, 20'h65535, 20'h00009, 20'h10000};
    seq_cnt = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

    chk("model_bcd_65535", to_bcd(65535), 20'h65535);
    chk("model_bcd_10000", to_bcd(10000), 20'h10000);

    wait_cyc(3);
    rst = 1'b0;

    // Idle with empty FIFOs
    wait_cyc(50);
    chk("idle_rd_count", rd_seen[0] + rd_seen[1] + rd_seen[2], 0);
    chk("idle_done_count", dn_seen[0] + dn_seen[1] + dn_seen[2], 0);
    chk("idle_bcd", bcd_o[0], 20'h00000);
    chk("idle_cnt", cnt_o[0], 8'd0);

    // Single token latency
    push(0, 16'd12345);
    wait_done(0, 1, 60);
    chk("lat_12345", dcyc[0][0] - rcyc[0][0], 17);
    wait_cyc(2);
    chk("bcd_12345", bcd_o[0], 20'h12345);
    chk("cnt_after_1", cnt_o[0], 8'd1);

    // Back-to-back tokens
    push(0, 16'd0);
    push(0, 16'd65535);
    push(0, 16'd9);
    push(0, 16'd10000);
    wait_done(0, 5, 150);
    wait_cyc(2);
    for (int k = 0; k < 4; k++) chk($sformatf("b2b_bcd%0d", k), obs_bcd[0][k+1], seq_bcd[k]);
    for (int k = 2; k < 5; k++) chk($sformatf("b2b_gap%0d", k), rcyc[0][k] - rcyc[0][k-1], 18);
    chk("b2b_cnt", cnt_o[0], 8'd5);

    // HOLD instance and narrow counter instance
    push(1, 16'd500);
    push(1, 16'd64000);
    for (int k = 1; k <= 5; k++) push(2, 16'(k * 11));
    wait_done(1, 2, 120);
    wait_done(2, 5, 200);
    wait_cyc(2);
    chk("hold_gap", rcyc[1][1] - rcyc[1][0], 21);
    chk("hold_bcd0", obs_bcd[1][0], 20'h00500);
    chk("hold_bcd1", obs_bcd[1][1], 20'h64000);
    for (int k = 0; k < 5; k++) chk($sformatf("wrap_cnt%0d", k), obs_cnt[2][k], seq_cnt[k]);
    chk("wrap_bcd_last", obs_bcd[2][4], 20'h00055);

    // Randomised traffic with bursty empty
    rnd_mode = 1;
    for (int it = 0; it < 40; it++) begin
      for (int g = 0; g < NI; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 5))
            0: push(g, 16'd0);
            1: push(g, 16'hFFFF);
            default: push(g, 16'($urandom));
          endcase
        end
      end
      wait_cyc($urandom_range(0, 20));
    end
    wait_idle(3000);
    rnd_mode = 0;
    wait_cyc(2);

    // Reset in the middle of a conversion
    b_rd = rd_seen[0];
    b_dn = dn_seen[0];
    push(0, 16'd4321);
    begin : wait_pop
      int t;
      t = 0;
      while (rd_seen[0] == b_rd && t < 20) begin
        wait_cyc(1);
        t++;
      end
      chk("rst_pop_timeout", rd_seen[0] != b_rd, 1'b1);
    end
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(2);
    chk("rst_bcd", bcd_o[0], 20'h00000);
    chk("rst_cnt", cnt_o[0], 8'd0);
    chk("rst_busy", busy_o[0], 1'b0);
    chk("rst_no_done", dn_seen[0], b_dn);
    rst = 1'b0;
    wait_cyc(2);
    push(0, 16'd77);
    wait_done(0, b_dn + 1, 60);
    wait_cyc(2);
    chk("post_rst_bcd", bcd_o[0], 20'h00077);
    chk("post_rst_cnt", cnt_o[0], 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
